// File: rtl/uart_pkg.sv
// Shared UART types and defaults: line FSM state encoding, default baud divisor and FIFO depth.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package uart_pkg;

  // 100 MHz core clock / 115200 baud
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_FIFO_DEPTH   = 16;

  // Baud counter width covers the full legal CLKS_PER_BIT range (up to 65535)
  localparam int BAUD_W = 16;

  // Common state encoding for both the transmit and receive line FSMs
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with an extra pointer MSB so all DEPTH entries are usable.
// Latency: a pushed byte is visible on pop_data the cycle after the push; read data is combinational from the head.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers differ only in the wrap bit when the FIFO holds DEPTH entries
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; simultaneous push and pop both advance, leaving occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_io_unit.sv
// 8N1 UART bridging the exec element's OUT/IN handshakes to txd/rxd through a TX FIFO and an RX FIFO.
// Latency: OUT accept pulses uart_in_ready next cycle, txd start edge 2 cycles later when idle; IN delivers 2 cycles after the RX stop sample.
// Backpressure: OUT stalls (uart_in_ready low) while TX FIFO is full; IN stalls while RX FIFO is empty; RX bytes are dropped when RX FIFO is full.
module uart_io_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  input  logic       uart_out_valid,
  output logic [7:0] uart_out_data,
  output logic       uart_out_ready,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  // Last count of a full bit period, and of the half period used to centre the RX sample point
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------------
  // TX side
  // ---------------------------------------------------------------------------
  logic              tx_push;
  logic              tx_pop;
  logic [7:0]        tx_fifo_data;
  logic              tx_full;
  logic              tx_empty;
  uart_state_t       tx_state;
  logic [BAUD_W-1:0] tx_baud;
  logic [2:0]        tx_bit;
  logic [7:0]        tx_shift;
  logic              tx_baud_end;

  // A request is taken only when no acceptance pulse is outstanding, so a held valid pushes once
  assign tx_push     = uart_in_valid && !uart_in_ready && !tx_full;
  assign tx_baud_end = (tx_baud == BIT_LAST);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (uart_in_data),
    .pop       (tx_pop),
    .pop_data  (tx_fifo_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Registered one-cycle OUT acceptance pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_in_ready <= 1'b0;
    end else begin
      uart_in_ready <= tx_push;
    end
  end

  // Pop the next byte when leaving IDLE or at the end of a stop bit, so frames run back to back
  always_comb begin
    tx_pop = 1'b0;
    case (tx_state)
      IDLE:    tx_pop = !tx_empty;
      STOP:    tx_pop = tx_baud_end && !tx_empty;
      default: tx_pop = 1'b0;
    endcase
  end

  // TX line FSM; txd is registered from the current state, trailing the state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        START:   txd <= 1'b0;
        DATA:    txd <= tx_shift[0];
        default: txd <= 1'b1;
      endcase

      case (tx_state)
        IDLE: begin
          tx_baud <= '0;
          tx_bit  <= '0;
          if (tx_pop) begin
            tx_shift <= tx_fifo_data;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_baud_end) begin
            tx_baud  <= '0;
            tx_state <= DATA;
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        DATA: begin
          if (tx_baud_end) begin
            tx_baud  <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) begin
              tx_bit   <= '0;
              tx_state <= STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        STOP: begin
          if (tx_baud_end) begin
            tx_baud <= '0;
            if (tx_pop) begin
              tx_shift <= tx_fifo_data;
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX side
  // ---------------------------------------------------------------------------
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic              rx_prev;
  logic              rx_push;
  logic              rx_pop;
  logic [7:0]        rx_fifo_data;
  logic              rx_full;
  logic              rx_empty;
  uart_state_t       rx_state;
  logic [BAUD_W-1:0] rx_baud;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              rx_baud_end;
  logic              rx_stop_sample;

  assign rx_s           = rx_sync[1];
  assign rx_baud_end    = (rx_baud == BIT_LAST);
  assign rx_stop_sample = (rx_state == STOP) && rx_baud_end;
  // A good stop bit lands the byte only if there is room; otherwise it is counted as overflow
  assign rx_push        = rx_stop_sample && rx_s && !rx_full;
  // Delivery is taken only when no delivery pulse is outstanding
  assign rx_pop         = uart_out_valid && !uart_out_ready && !rx_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (rx_fifo_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Two-flop synchronizer for the asynchronous line plus a delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  // RX line FSM: centre on the start bit, sample each bit mid-period, judge the stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= IDLE;
      rx_baud      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      case (rx_state)
        IDLE: begin
          rx_baud <= '0;
          rx_bit  <= '0;
          if (rx_prev && !rx_s) begin
            rx_state <= START;
          end
        end
        START: begin
          if (rx_baud == HALF_LAST) begin
            rx_baud <= '0;
            // A line already back high at mid-start is a glitch, not a frame
            rx_state <= rx_s ? IDLE : DATA;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        DATA: begin
          if (rx_baud_end) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_bit   <= '0;
              rx_state <= STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        STOP: begin
          if (rx_baud_end) begin
            rx_baud  <= '0;
            rx_state <= IDLE;
            if (!rx_s) begin
              rx_frame_err <= 1'b1;
            end else if (rx_full) begin
              rx_overflow <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Registered IN delivery: byte and one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_out_ready <= 1'b0;
      uart_out_data  <= '0;
    end else begin
      uart_out_ready <= rx_pop;
      if (rx_pop) begin
        uart_out_data <= rx_fifo_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_io_unit.sv
// Self-checking bench for uart_io_unit with a short bit period and a 4-entry FIFO.
// Latency: checks OUT/IN pulse timing and the txd waveform against a frame-level model.
// Backpressure: exercises TX-full stalls, RX-empty stalls, RX overflow and framing errors.
module tb_uart_io_unit;

  localparam int CPB = 4;
  localparam int FD  = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] uart_in_data = 8'h00;
  logic       uart_in_valid = 1'b0;
  logic       uart_in_ready;
  logic       uart_out_valid = 1'b0;
  logic [7:0] uart_out_data;
  logic       uart_out_ready;
  logic       rxd = 1'b1;
  logic       txd;
  logic       rx_overflow;
  logic       rx_frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int frame_f = 0;

  uart_io_unit #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .uart_out_valid (uart_out_valid),
    .uart_out_data  (uart_out_data),
    .uart_out_ready (uart_out_ready),
    .rxd            (rxd),
    .txd            (txd),
    .rx_overflow    (rx_overflow),
    .rx_frame_err   (rx_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level decoder of txd: finds a start edge, samples each bit mid-period
  bit         mon_en = 1'b0;
  logic [7:0] tx_got[$];
  int         tx_start[$];
  int         tx_stop_bad = 0;

  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    int         s;
    prev = 1'b1;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && txd === 1'b0) begin
        s = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (mon_en) begin
          if (txd !== 1'b1) tx_stop_bad++;
          tx_got.push_back(b);
          tx_start.push_back(s);
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus helpers (no checks inside)
  task automatic do_out(input logic [7:0] d, input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    @(posedge clk); #1;
    uart_in_data  = d;
    uart_in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uart_in_ready === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    uart_in_valid = 1'b0;
  endtask

  task automatic do_in(input int budget, output bit ok, output logic [7:0] d, output int at);
    ok = 1'b0;
    at = -1;
    d  = 8'h00;
    @(posedge clk); #1;
    uart_out_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uart_out_ready === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        d  = uart_out_data;
        break;
      end
    end
    @(posedge clk); #1;
    uart_out_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rxd = bits[i];
      if (i == 0) frame_f = cyc;
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  task automatic clear_mon();
    tx_got.delete();
    tx_start.delete();
    tx_stop_bad = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int lows;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL rst_txd: got %b want 1", txd); end
    n_cmp++; if (uart_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", uart_in_ready); end
    n_cmp++; if (uart_out_ready !== 1'b0) begin n_bad++; $display("FAIL rst_out_ready: got %b want 0", uart_out_ready); end
    n_cmp++; if (uart_out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %h want 00", uart_out_data); end
    n_cmp++; if (rx_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", rx_overflow); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_frame_err: got %b want 0", rx_frame_err); end
    @(posedge clk); #1;
    reset = 1'b0;
    lows = 0;
    repeat (12) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL rst_idle_line: got %0d low cycles want 0", lows); end
  endtask

  task automatic test_tx_single();
    bit         ok;
    int         p;
    int         k;
    int         extra;
    logic [9:0] frm;
    logic       exp_b;
    clear_mon();
    mon_en = 1'b1;
    do_out(8'hA5, 20, ok, p);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tx1_accept: got no uart_in_ready want pulse"); end
    frm = {1'b1, 8'hA5, 1'b0};
    extra = 0;
    // Pulse at cycle p; line idle at p+1; start bit from p+2; each bit CPB cycles
    for (int n = 0; n < FRAME + 3; n++) begin
      @(negedge clk);
      k = cyc - p;
      if (uart_in_ready === 1'b1) extra++;
      if (k < 2 || (k - 2) / CPB >= 10) exp_b = 1'b1;
      else exp_b = frm[(k - 2) / CPB];
      n_cmp++;
      if (txd !== exp_b) begin n_bad++; $display("FAIL tx1_wave: cycle +%0d got %b want %b", k, txd, exp_b); end
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL tx1_single_pulse: got %0d extra pulses want 0", extra); end
    repeat (20) @(posedge clk);
    n_cmp++;
    if (tx_got.size() != 1) begin n_bad++; $display("FAIL tx1_frames: got %0d frames want 1", tx_got.size()); end
    else if (tx_got[0] !== 8'hA5) begin n_bad++; $display("FAIL tx1_frames: got %h want a5", tx_got[0]); end
  endtask

  task automatic test_rx_single();
    bit         ok;
    logic [7:0] d;
    int         at;
    int         exp_at;
    fork
      send_frame(8'h3C, 1'b1);
      do_in(200, ok, d, at);
    join
    // 2 sync flops, then mid-start sample, 9 more bit periods to mid-stop, then 2 cycles to delivery
    exp_at = frame_f + 2 + CPB / 2 + 9 * CPB + 2;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rx1_deliver: got no uart_out_ready want pulse"); end
    n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL rx1_data: got %h want 3c", d); end
    n_cmp++; if (at != exp_at) begin n_bad++; $display("FAIL rx1_latency: got cycle %0d want %0d", at, exp_at); end
    do_in(40, ok, d, at);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL rx1_empty_stall: got pulse data %h want stall", d); end
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         at;
    int         rdy[5];
    logic [7:0] d;
    logic [7:0] exp_q[$];
    clear_mon();
    mon_en = 1'b1;
    d = 8'($urandom);
    do_out(d, 20, ok, at);
    exp_q.push_back(d);
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      do_out(d, 200, ok, rdy[i]);
      exp_q.push_back(d);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_accept: out %0d got no pulse want pulse", i); end
    end
    repeat (6 * FRAME + 20) @(posedge clk);
    n_cmp++;
    if (tx_got.size() != 6) begin
      n_bad++; $display("FAIL b2b_frames: got %0d frames want 6", tx_got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (tx_got[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data: frame %0d got %h want %h", i, tx_got[i], exp_q[i]); end
      end
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (tx_start[i] - tx_start[i-1] != FRAME) begin
          n_bad++; $display("FAIL b2b_gap: frame %0d spacing got %0d want %0d", i, tx_start[i] - tx_start[i-1], FRAME);
        end
      end
      // Fifth OUT must wait for the first of the five to leave the FIFO, i.e. its frame starting
      n_cmp++;
      if (rdy[4] < tx_start[1] - 1 || rdy[4] > tx_start[1] + 2) begin
        n_bad++; $display("FAIL b2b_stall: 5th pulse cycle %0d want near frame start %0d", rdy[4], tx_start[1]);
      end
    end
    n_cmp++; if (tx_stop_bad != 0) begin n_bad++; $display("FAIL b2b_stop: got %0d bad stop bits want 0", tx_stop_bad); end
  endtask

  task automatic test_rx_overflow();
    bit         ok;
    int         at;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    for (int i = 0; i < FD + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      if (exp_q.size() < FD) exp_q.push_back(b);
    end
    repeat (10) @(posedge clk);
    n_cmp++; if (rx_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL ovf_no_frame_err: got %b want 0", rx_frame_err); end
    for (int i = 0; i < FD; i++) begin
      do_in(20, ok, d, at);
      b = exp_q.pop_front();
      n_cmp++;
      if (!ok || d !== b) begin n_bad++; $display("FAIL ovf_order: entry %0d got %h (ok=%0d) want %h", i, d, ok, b); end
    end
    do_in(30, ok, d, at);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL ovf_dropped: got extra byte %h want stall", d); end
  endtask

  task automatic test_frame_err();
    bit         ok;
    int         at;
    logic [7:0] d;
    logic [7:0] b;
    send_frame(8'($urandom), 1'b0);
    repeat (10) @(posedge clk);
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", rx_frame_err); end
    n_cmp++; if (rx_overflow !== 1'b1) begin n_bad++; $display("FAIL ferr_ovf_sticky: got %b want 1", rx_overflow); end
    do_in(30, ok, d, at);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL ferr_discard: got byte %h want stall", d); end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    do_in(20, ok, d, at);
    n_cmp++; if (!ok || d !== b) begin n_bad++; $display("FAIL ferr_recover: got %h (ok=%0d) want %h", d, ok, b); end
  endtask

  task automatic test_glitch();
    bit         ok;
    int         at;
    logic [7:0] d;
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (FRAME + 20) @(posedge clk);
    do_in(20, ok, d, at);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL glitch_push: got byte %h want stall", d); end
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL glitch_sticky: frame_err got %b want 1", rx_frame_err); end
  endtask

  task automatic test_random_traffic();
    bit         ok_t;
    bit         ok_r;
    int         at_t;
    int         at_r;
    int         n;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    for (int it = 0; it < 3; it++) begin
      clear_mon();
      mon_en = 1'b1;
      exp_tx.delete();
      exp_rx.delete();
      n = $urandom_range(1, 3);
      fork
        begin
          for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_tx.push_back(b);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            do_out(b, 200, ok_t, at_t);
          end
        end
        begin
          for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            exp_rx.push_back(d);
            send_frame(d, 1'b1);
          end
        end
      join
      for (int i = 0; i < n; i++) begin
        do_in(20, ok_r, d, at_r);
        b = exp_rx.pop_front();
        n_cmp++;
        if (!ok_r || d !== b) begin n_bad++; $display("FAIL rnd_rx: iter %0d byte %0d got %h (ok=%0d) want %h", it, i, d, ok_r, b); end
      end
      repeat (n * FRAME + 20) @(posedge clk);
      n_cmp++;
      if (tx_got.size() != n) begin
        n_bad++; $display("FAIL rnd_tx_count: iter %0d got %0d frames want %0d", it, tx_got.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (tx_got[i] !== exp_tx[i]) begin n_bad++; $display("FAIL rnd_tx: iter %0d frame %0d got %h want %h", it, i, tx_got[i], exp_tx[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    bit         ok;
    int         at;
    int         lows;
    logic [7:0] d;
    logic [7:0] b;
    mon_en = 1'b0;
    // Leave one byte waiting in RX and three queued for TX (all-zero first byte keeps txd low mid-frame)
    send_frame(8'($urandom), 1'b1);
    do_out(8'h00, 20, ok, at);
    do_out(8'($urandom), 20, ok, at);
    do_out(8'($urandom), 20, ok, at);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL rmid_pre: txd got %b want 0 mid-frame", txd); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL rmid_txd: got %b want 1", txd); end
    n_cmp++; if (rx_overflow !== 1'b0 || rx_frame_err !== 1'b0) begin
      n_bad++; $display("FAIL rmid_flags: got ovf=%b ferr=%b want 0 0", rx_overflow, rx_frame_err);
    end
    n_cmp++; if (uart_out_data !== 8'h00) begin n_bad++; $display("FAIL rmid_out_data: got %h want 00", uart_out_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    lows = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL rmid_tx_empty: got %0d low cycles want 0", lows); end
    do_in(20, ok, d, at);
    n_cmp++; if (ok) begin n_bad++; $display("FAIL rmid_rx_empty: got byte %h want stall", d); end
    clear_mon();
    mon_en = 1'b1;
    b = 8'($urandom);
    do_out(b, 20, ok, at);
    repeat (FRAME + 10) @(posedge clk);
    n_cmp++;
    if (tx_got.size() != 1 || tx_got[0] !== b) begin
      n_bad++; $display("FAIL rmid_recover: got %0d frames want 1 frame of %h", tx_got.size(), b);
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_rx_single();
    test_back_to_back();
    test_rx_overflow();
    test_frame_err();
    test_glitch();
    test_random_traffic();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
